micro_seq: RTL and testbench

MICRO_SEQ -- requirements
Module: micro_seq

---
 rtl/micro_seq_pkg.sv | 41 ++++
 rtl/micro_seq_if.sv | 13 +
 rtl/micro_stack.sv | 50 +++++
 rtl/micro_seq.sv | 139 +++++++++++++
 tb/tb_micro_seq.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_seq_pkg.sv
// Shared microword layout, opcodes, FSM states and default parameters for the microsequencer.
// Pure definitions: no logic, no latency, no flow control.
package micro_seq_pkg;

    localparam int          DEF_STACK_DEPTH = 4;
    localparam logic [11:0] DEF_RESET_ADDR  = 12'h000;
    localparam int          DEF_RDY_TIMEOUT = 15;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 16;

    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 16;
    localparam int CSEL_MSB = 15;
    localparam int CSEL_LSB = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 0;

    localparam logic [3:0] OP_CONT  = 4'd0;
    localparam logic [3:0] OP_JMP   = 4'd1;
    localparam logic [3:0] OP_JCOND = 4'd2;
    localparam logic [3:0] OP_CALL  = 4'd3;
    localparam logic [3:0] OP_RET   = 4'd4;
    localparam logic [3:0] OP_CALLC = 4'd5;
    localparam logic [3:0] OP_RETC  = 4'd6;
    localparam logic [3:0] OP_MAP   = 4'd7;
    localparam logic [3:0] OP_WAIT  = 4'd8;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAITRDY = 2'd1,
        S_EXEC    = 2'd2
    } state_e;

    function automatic logic [31:0] mk_uword(input logic [3:0] op, input logic [3:0] csel,
                                             input logic [11:0] addr);
        return {12'h000, op, csel, addr};
    endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Control-store bus between the microsequencer (master) and the microcode ROM (slave).
// Request is a one-cycle pulse; ready returns one cycle later with the microword.
interface micro_seq_if;
    import micro_seq_pkg::*;

    logic [AW-1:0] MPC;
    logic          ROMRQ;
    logic [DW-1:0] ROM;
    logic          ROMDRY;

    modport master (output MPC, output ROMRQ, input ROM, input ROMDRY);
    modport slave  (input MPC, input ROMRQ, output ROM, output ROMDRY);
endinterface

// File: rtl/micro_stack.sv
// Microcode return stack; push/pop take effect on the clock edge, top is combinational.
// No backpressure: a push when full silently drops the oldest entry, a pop when empty is a no-op.
module micro_stack
    import micro_seq_pkg::*;
#(
    parameter int DEPTH = DEF_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] push_dat_i,
    output logic [AW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);

    logic [AW-1:0]   mem_q [DEPTH];
    logic [CNTW-1:0] cnt_q;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   wr_idx;

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_idx = IW'(cnt_q - CNTW'(1));
    assign wr_idx  = IW'(cnt_q);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    // Entry 0 is always the oldest, so discard-on-full is a shift toward index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push_i) begin
            if (full_o) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
                mem_q[DEPTH-1] <= push_dat_i;
            end else begin
                mem_q[wr_idx] <= push_dat_i;
                cnt_q         <= cnt_q + CNTW'(1);
            end
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

endmodule

// File: rtl/micro_seq.sv
// Microprogram sequencer: fetch / wait-for-ready / execute, at least 3 cycles per microword.
// HOLD freezes EXEC; a missing ROMDRY times out and the same address is re-requested.
module micro_seq
    import micro_seq_pkg::*;
#(
    parameter int          STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [11:0] RESET_ADDR  = DEF_RESET_ADDR,
    parameter int          RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    micro_seq_if.master    rom,
    input  logic [CW-1:0]  COND,
    input  logic [AW-1:0]  MAPADDR,
    input  logic           HOLD,
    input  logic           TRAP,
    input  logic [AW-1:0]  TRAPVEC,
    output logic [DW-1:0]  UIR,
    output logic           UVALID,
    output logic           SOVF,
    output logic           SUNF,
    output logic           ROMTO
);
    localparam int TW = $clog2(RDY_TIMEOUT + 1);

    state_e        state_q;
    logic [AW-1:0] mpc_q;
    logic [AW-1:0] mpc_d;
    logic [DW-1:0] uir_q;
    logic          sovf_q, sunf_q, romto_q;
    logic [TW-1:0] tmo_q;

    logic [3:0]    op;
    logic [3:0]    csel;
    logic [AW-1:0] addr;
    logic          cond_bit;
    logic [AW-1:0] mpc_inc;
    logic          push, pop, exec_go;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    assign op       = uir_q[OP_MSB:OP_LSB];
    assign csel     = uir_q[CSEL_MSB:CSEL_LSB];
    assign addr     = uir_q[ADDR_MSB:ADDR_LSB];
    assign cond_bit = COND[csel];
    assign mpc_inc  = mpc_q + AW'(1);
    assign exec_go  = (state_q == S_EXEC) && !HOLD;

    always_comb begin
        mpc_d = mpc_inc;
        push  = 1'b0;
        pop   = 1'b0;
        if (TRAP) begin
            push  = 1'b1;
            mpc_d = TRAPVEC;
        end else begin
            case (op)
                OP_JMP:   mpc_d = addr;
                OP_JCOND: if (cond_bit) mpc_d = addr;
                OP_CALL: begin
                    push  = 1'b1;
                    mpc_d = addr;
                end
                OP_CALLC: if (cond_bit) begin
                    push  = 1'b1;
                    mpc_d = addr;
                end
                OP_RET:   pop = 1'b1;
                OP_RETC:  pop = cond_bit;
                OP_MAP:   mpc_d = MAPADDR;
                OP_WAIT:  if (!cond_bit) mpc_d = mpc_q;
                default:  mpc_d = mpc_inc;
            endcase
            if (pop) begin
                mpc_d = stk_empty ? RESET_ADDR : stk_top;
            end
        end
    end

    micro_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk        (clk),
        .rst        (rst),
        .push_i     (exec_go && push),
        .pop_i      (exec_go && pop),
        .push_dat_i (mpc_inc),
        .top_o      (stk_top),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            mpc_q   <= RESET_ADDR;
            uir_q   <= '0;
            sovf_q  <= 1'b0;
            sunf_q  <= 1'b0;
            romto_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    tmo_q   <= '0;
                    state_q <= S_WAITRDY;
                end
                S_WAITRDY: begin
                    if (rom.ROMDRY) begin
                        uir_q   <= rom.ROM;
                        state_q <= S_EXEC;
                    end else if (tmo_q == TW'(RDY_TIMEOUT - 1)) begin
                        romto_q <= 1'b1;
                        state_q <= S_FETCH;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_EXEC: begin
                    if (!HOLD) begin
                        mpc_q   <= mpc_d;
                        state_q <= S_FETCH;
                        if (push && stk_full) sovf_q <= 1'b1;
                        if (pop && stk_empty) sunf_q <= 1'b1;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Request is gated by rst so the bus stays quiet while reset is held.
    assign rom.MPC   = mpc_q;
    assign rom.ROMRQ = (state_q == S_FETCH) && !rst;
    assign UIR       = uir_q;
    assign UVALID    = (state_q == S_EXEC);
    assign SOVF      = sovf_q;
    assign SUNF      = sunf_q;
    assign ROMTO     = romto_q;

endmodule

// File: tb/tb_micro_seq.sv
// Bench for micro_seq: a ROM model answers requests, and a scoreboard compares every fetch address
// against the sequence each test expects; tests check flags, UIR and timing inline.
module tb_micro_seq;
    import micro_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] COND = '0;
    logic [11:0] MAPADDR = '0;
    logic        HOLD = 1'b0;
    logic        TRAP = 1'b0;
    logic [11:0] TRAPVEC = '0;
    logic [31:0] UIR;
    logic        UVALID, SOVF, SUNF, ROMTO;

    micro_seq_if rom_if ();

    micro_seq #(.STACK_DEPTH(4), .RESET_ADDR(12'h000), .RDY_TIMEOUT(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .rom     (rom_if),
        .COND    (COND),
        .MAPADDR (MAPADDR),
        .HOLD    (HOLD),
        .TRAP    (TRAP),
        .TRAPVEC (TRAPVEC),
        .UIR     (UIR),
        .UVALID  (UVALID),
        .SOVF    (SOVF),
        .SUNF    (SUNF),
        .ROMTO   (ROMTO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ROM model: ready one cycle after the request, or two when 'late' is set.
    logic [31:0] rom_mem [4096];
    logic        withhold = 1'b0;
    logic        late = 1'b0;
    logic        d1 = 1'b0, d2 = 1'b0;
    logic [11:0] a1 = '0, a2 = '0;

    always @(negedge clk) begin
        rom_if.ROMDRY = late ? d2 : d1;
        rom_if.ROM    = rom_mem[late ? a2 : a1];
        d2 = d1;
        a2 = a1;
        d1 = rom_if.ROMRQ && !withhold;
        a1 = rom_if.MPC;
    end

    logic [11:0] exp_q [$];
    int          rq_cyc [$];
    int          checks = 0;
    int          failures = 0;
    logic [11:0] mon_e;

    always @(negedge clk) begin
        if (rom_if.ROMRQ) begin
            rq_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (rom_if.MPC !== mon_e) begin
                    failures++;
                    $display("FAIL fetch_addr got=%h exp=%h cyc=%0d", rom_if.MPC, mon_e, cyc);
                end
            end
        end
    end

    task automatic hold_reset(input logic lt);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        HOLD     = 1'b0;
        TRAP     = 1'b0;
        COND     = '0;
        withhold = 1'b0;
        late     = lt;
        exp_q.delete();
        rq_cyc.delete();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_left(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() <= n) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        hold_reset(1'b0);
        @(negedge clk);
        checks++;
        if (rom_if.MPC !== 12'h000) begin failures++; $display("FAIL rst_mpc got=%h exp=000", rom_if.MPC); end
        checks++;
        if (rom_if.ROMRQ !== 1'b0) begin failures++; $display("FAIL rst_romrq got=%b exp=0", rom_if.ROMRQ); end
        checks++;
        if (UVALID !== 1'b0 || UIR !== 32'h0) begin failures++; $display("FAIL rst_uir got=%b/%h exp=0/0", UVALID, UIR); end
        checks++;
        if ({SOVF, SUNF, ROMTO} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {SOVF, SUNF, ROMTO}); end
        release_reset();
        @(negedge clk);
        checks++;
        if (rom_if.ROMRQ !== 1'b1) begin failures++; $display("FAIL first_romrq got=%b exp=1", rom_if.ROMRQ); end
        @(negedge clk);
        checks++;
        if (rom_if.ROMRQ !== 1'b0) begin failures++; $display("FAIL romrq_pulse got=%b exp=0", rom_if.ROMRQ); end
    endtask

    task automatic test_cont();
        hold_reset(1'b0);
        exp_q = '{12'h000, 12'h001, 12'h002};
        release_reset();
        wait_left(0, 40);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL cont_drain got=%0d exp=0", exp_q.size()); end
        checks++;
        if (rq_cyc.size() < 3) begin
            failures++;
            $display("FAIL cont_spacing got=%0d requests exp=3", rq_cyc.size());
        end else if (rq_cyc[1] - rq_cyc[0] != 3 || rq_cyc[2] - rq_cyc[1] != 3) begin
            failures++;
            $display("FAIL cont_spacing got=%0d,%0d exp=3,3", rq_cyc[1] - rq_cyc[0], rq_cyc[2] - rq_cyc[1]);
        end
    endtask

    task automatic test_call_ret();
        hold_reset(1'b0);
        rom_mem[12'h000] = mk_uword(OP_JMP, 4'h0, 12'h010);
        rom_mem[12'h010] = mk_uword(OP_CALL, 4'h0, 12'h100);
        rom_mem[12'h100] = mk_uword(OP_RET, 4'h0, 12'h000);
        exp_q = '{12'h000, 12'h010, 12'h100, 12'h011};
        release_reset();
        wait_left(0, 60);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL callret_drain got=%0d exp=0", exp_q.size()); end
        checks++;
        if ({SOVF, SUNF} !== 2'b00) begin failures++; $display("FAIL callret_flags got=%b exp=00", {SOVF, SUNF}); end
    endtask

    task automatic test_overflow();
        hold_reset(1'b0);
        rom_mem[12'h000] = mk_uword(OP_CALL, 4'h0, 12'h010);
        rom_mem[12'h010] = mk_uword(OP_CALL, 4'h0, 12'h020);
        rom_mem[12'h020] = mk_uword(OP_CALL, 4'h0, 12'h030);
        rom_mem[12'h030] = mk_uword(OP_CALL, 4'h0, 12'h040);
        rom_mem[12'h040] = mk_uword(OP_CALL, 4'h0, 12'h050);
        rom_mem[12'h050] = mk_uword(OP_RET, 4'h0, 12'h000);
        rom_mem[12'h041] = mk_uword(OP_RET, 4'h0, 12'h000);
        rom_mem[12'h031] = mk_uword(OP_RET, 4'h0, 12'h000);
        rom_mem[12'h021] = mk_uword(OP_RET, 4'h0, 12'h000);
        rom_mem[12'h011] = mk_uword(OP_RET, 4'h0, 12'h000);
        exp_q = '{12'h000, 12'h010, 12'h020, 12'h030, 12'h040, 12'h050,
                  12'h041, 12'h031, 12'h021, 12'h011, 12'h000};
        release_reset();
        wait_left(1, 100);
        checks++;
        if ({SOVF, SUNF} !== 2'b10) begin failures++; $display("FAIL ovf_mid got=%b exp=10", {SOVF, SUNF}); end
        wait_left(0, 20);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", exp_q.size()); end
        checks++;
        if ({SOVF, SUNF} !== 2'b11) begin failures++; $display("FAIL ovf_end got=%b exp=11", {SOVF, SUNF}); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            hold_reset(1'b0);
            COND = (k == 0) ? 16'hFFF7 : 16'h0008;
            rom_mem[12'h000] = mk_uword(OP_JMP, 4'h0, 12'hFFF);
            rom_mem[12'hFFF] = mk_uword(OP_JCOND, 4'h3, 12'h123);
            exp_q = '{12'h000, 12'hFFF, (k == 0) ? 12'h000 : 12'h123};
            release_reset();
            wait_left(0, 40);
            checks++;
            if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_drain k=%0d got=%0d exp=0", k, exp_q.size()); end
        end
    endtask

    task automatic test_branches();
        hold_reset(1'b0);
        COND    = 16'h0004;
        MAPADDR = 12'h040;
        rom_mem[12'h000] = mk_uword(OP_MAP, 4'h0, 12'h000);
        rom_mem[12'h040] = mk_uword(OP_CALLC, 4'h1, 12'h080);
        rom_mem[12'h041] = mk_uword(OP_CALLC, 4'h2, 12'h080);
        rom_mem[12'h080] = mk_uword(OP_RETC, 4'h1, 12'h000);
        rom_mem[12'h081] = mk_uword(OP_WAIT, 4'h2, 12'h000);
        rom_mem[12'h082] = mk_uword(OP_RETC, 4'h2, 12'h000);
        rom_mem[12'h042] = mk_uword(4'hF, 4'h0, 12'h3AB);
        exp_q = '{12'h000, 12'h040, 12'h041, 12'h080, 12'h081, 12'h082, 12'h042, 12'h043};
        release_reset();
        wait_left(0, 80);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL branch_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_hold_trap();
        logic [31:0] w;
        w = mk_uword(OP_JMP, 4'h0, 12'h200);
        hold_reset(1'b0);
        rom_mem[12'h000] = w;
        rom_mem[12'h7F0] = mk_uword(OP_RET, 4'h0, 12'h000);
        HOLD  = 1'b1;
        exp_q = '{12'h000, 12'h7F0, 12'h001};
        release_reset();
        for (int i = 0; i < 20 && UVALID !== 1'b1; i++) @(negedge clk);
        checks++;
        if (UVALID !== 1'b1) begin failures++; $display("FAIL hold_enter got=%b exp=1", UVALID); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (UIR !== w || rom_if.MPC !== 12'h000 || UVALID !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable i=%0d got=%h/%h/%b exp=%h/000/1", i, UIR, rom_if.MPC, UVALID, w);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        HOLD    = 1'b0;
        TRAP    = 1'b1;
        TRAPVEC = 12'h7F0;
        @(posedge clk);
        #1;
        TRAP = 1'b0;
        checks++;
        if (rom_if.MPC !== 12'h7F0) begin failures++; $display("FAIL trap_mpc got=%h exp=7f0", rom_if.MPC); end
        wait_left(0, 40);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL trap_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        hold_reset(1'b0);
        withhold = 1'b1;
        exp_q = '{12'h000, 12'h000, 12'h001};
        release_reset();
        wait_left(2, 10);
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (ROMTO !== 1'b0) begin failures++; $display("FAIL romto_early got=%b exp=0", ROMTO); end
        withhold = 1'b0;
        wait_left(0, 60);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL tmo_drain got=%0d exp=0", exp_q.size()); end
        checks++;
        if (ROMTO !== 1'b1) begin failures++; $display("FAIL romto_set got=%b exp=1", ROMTO); end
        checks++;
        if (rq_cyc.size() < 2) begin
            failures++;
            $display("FAIL tmo_spacing got=%0d requests exp=2", rq_cyc.size());
        end else if (rq_cyc[1] - rq_cyc[0] != 16) begin
            failures++;
            $display("FAIL tmo_spacing got=%0d exp=16", rq_cyc[1] - rq_cyc[0]);
        end
    endtask

    task automatic test_reset_in_wait();
        hold_reset(1'b1);
        rom_mem[12'h000] = mk_uword(OP_JMP, 4'h0, 12'h300);
        exp_q = '{12'h000, 12'h000, 12'h300};
        release_reset();
        wait_left(2, 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rom_if.ROMRQ !== 1'b1 || rom_if.MPC !== 12'h000) begin
            failures++;
            $display("FAIL rstwait_refetch got=%b/%h exp=1/000", rom_if.ROMRQ, rom_if.MPC);
        end
        @(negedge clk);
        #1;
        checks++;
        if (UVALID !== 1'b0 || UIR !== 32'h0) begin
            failures++;
            $display("FAIL rstwait_ignored got=%b/%h exp=0/0", UVALID, UIR);
        end
        wait_left(0, 40);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rstwait_drain got=%0d exp=0", exp_q.size()); end
        late = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cont();
        test_call_ret();
        test_overflow();
        test_wrap();
        test_branches();
        test_hold_trap();
        test_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
